// File: rtl/fpf_rx_decoder_20_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpf_rx_decoder_20_if
//  Description : Handshake/data bundle between the FPF receive decoder and
//                its neighbours.
//                  tsv_in    - received TSV word (N bits)
//                  in_valid  - tsv_in is valid
//                  in_ready  - decoder accepts tsv_in this cycle
//                  out_data  - decoded binary value (DW bits)
//                  out_err   - decoded word contained a forbidden pattern
//                  out_valid - out_data/out_err are valid
//                  out_ready - downstream consumes the result
//                The decoder uses the slave modport; its environment uses
//                the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpf_rx_decoder_20_if #(
    parameter int N  = 20,
    parameter int DW = 15
);
    logic [N-1:0]  tsv_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output tsv_in, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  tsv_in, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fpf_rx_decoder_20.sv
`default_nettype none
// ============================================================================
//  Module      : fpf_rx_decoder_20
//  Description : Receiver-side decoder for the 20-TSV FPF crosstalk-avoidance
//                link. Captures one TSV word, flags forbidden 101/010
//                patterns and converts the word from the Fibonacci numeral
//                system to binary over N/BPC accumulate cycles.
//  Ports       : clock     - system clock, rising edge
//                reset_n   - synchronous active-low reset
//                bus       - fpf_rx_decoder_20_if.slave (input word in,
//                            decoded value/error out, valid/ready both sides)
//                err_count - 16-bit saturating forbidden-pattern counter
//                            (only when FPF_RX_ERRCNT_EN is defined)
//  Options     : FPF_RX_ERRCNT_EN - adds the err_count port and counter
//  Revision    : 1.0 - initial release
// ============================================================================
module fpf_rx_decoder_20 #(
    parameter int N   = 20,
    parameter int DW  = 15,
    parameter int BPC = 1
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    fpf_rx_decoder_20_if.slave bus
`ifdef FPF_RX_ERRCNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time legality check of the beat width
    // ------------------------------------------------------------------
    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 5 ||
              BPC == 10 || BPC == 20)) begin : g_bpc_illegal
            $error("fpf_rx_decoder_20: BPC must be one of 1,2,4,5,10,20");
        end
    endgenerate

    localparam int K  = N / BPC;          // beats per word
    localparam int BW = $clog2(K + 1);    // beat counter width
    localparam int PW = $clog2(N + 1);    // bit position width

    // ------------------------------------------------------------------
    // Constant FNS weight table: w[0]=w[1]=1, w[k]=w[k-1]+w[k-2]
    // ------------------------------------------------------------------
    typedef logic [N-1:0][DW-1:0] wtab_t;

    function automatic wtab_t fib_table();
        wtab_t t;
        t    = '0;
        t[0] = DW'(1);
        t[1] = DW'(1);
        for (int k = 2; k < N; k++) begin
            t[k] = t[k-1] + t[k-2];
        end
        return t;
    endfunction

    localparam wtab_t W_TAB = fib_table();

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [N-1:0]  word_q,     word_d;
    logic [DW-1:0] acc_q,      acc_d;
    logic [PW-1:0] pos_q,      pos_d;
    logic [BW-1:0] beat_q,     beat_d;
    logic          flag_q,     flag_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_err_q,  out_err_d;
    logic          out_valid_q, out_valid_d;

    logic          w_in_ready;
    logic          w_capture;
    logic          w_last;
    logic          w_fpf_err;
    logic [DW-1:0] w_beat_sum;

    // A window (k,k+1,k+2) is 101 or 010 exactly when both neighbouring
    // bit pairs differ.
    always_comb begin
        w_fpf_err = 1'b0;
        for (int k = 0; k < N - 2; k++) begin
            if ((bus.tsv_in[k] != bus.tsv_in[k+1]) &&
                (bus.tsv_in[k+1] != bus.tsv_in[k+2])) begin
                w_fpf_err = 1'b1;
            end
        end
    end

    // BPC-input mux-add of the weights at the current bit position
    always_comb begin
        w_beat_sum = '0;
        for (int b = 0; b < BPC; b++) begin
            if (word_q[pos_q + PW'(b)]) begin
                w_beat_sum = w_beat_sum + W_TAB[pos_q + PW'(b)];
            end
        end
    end

    assign w_in_ready = (state_q == S_IDLE) ||
                        ((state_q == S_DONE) && bus.out_ready);
    assign w_capture  = w_in_ready && bus.in_valid;
    assign w_last     = (beat_q == BW'(K - 1));

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        acc_d       = acc_q;
        pos_d       = pos_q;
        beat_d      = beat_q;
        flag_d      = flag_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_ACC: begin
                acc_d  = acc_q + w_beat_sum;
                pos_d  = pos_q + PW'(BPC);
                beat_d = beat_q + BW'(1);
                if (w_last) begin
                    out_data_d  = acc_q + w_beat_sum;
                    out_err_d   = flag_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture overrides the IDLE/DONE decisions above so a DONE word
        // can be consumed and replaced on the same edge.
        if (w_capture) begin
            word_d  = bus.tsv_in;
            acc_d   = '0;
            pos_d   = '0;
            beat_d  = '0;
            flag_d  = w_fpf_err;
            state_d = S_ACC;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            acc_q       <= '0;
            pos_q       <= '0;
            beat_q      <= '0;
            flag_q      <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            pos_q       <= pos_d;
            beat_q      <= beat_d;
            flag_q      <= flag_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;

`ifdef FPF_RX_ERRCNT_EN
    // Counts on the DONE-load edge only; saturates instead of wrapping.
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == S_ACC) && w_last && flag_q &&
            (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    // No error counter in this build.
`endif

endmodule
`default_nettype wire
